// File: rtl/rv32i_types.sv
// Shared RV32I types: load/store funct3 encodings and the memory unit state.
package rv32i_types;

  localparam logic [2:0] load_f3_lb  = 3'b000;
  localparam logic [2:0] load_f3_lh  = 3'b001;
  localparam logic [2:0] load_f3_lw  = 3'b010;
  localparam logic [2:0] load_f3_lbu = 3'b100;
  localparam logic [2:0] load_f3_lhu = 3'b101;

  localparam logic [2:0] store_f3_sb = 3'b000;
  localparam logic [2:0] store_f3_sh = 3'b001;
  localparam logic [2:0] store_f3_sw = 3'b010;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_REQ,
    DMEM_WAIT,
    DMEM_DRAIN
  } dmem_state_t;

endpackage

// File: rtl/dmem_unit_if.sv
// Bundle of the issue, data-memory and writeback signals of the memory unit.
interface dmem_unit_if #(
  parameter int PHYS_WIDTH     = 6,
  parameter int ROB_ADDR_WIDTH = 5
);
  logic                      br_flush;
  logic                      req_valid;
  logic                      req_store;
  logic [2:0]                req_funct3;
  logic [31:0]               req_rs1_data;
  logic [31:0]               req_rs2_data;
  logic [31:0]               req_imm;
  logic [PHYS_WIDTH-1:0]     req_pd;
  logic [ROB_ADDR_WIDTH-1:0] req_rob_idx;
  logic                      stall_mem;

  logic [31:0]               dmem_addr;
  logic [3:0]                dmem_rmask;
  logic [3:0]                dmem_wmask;
  logic [31:0]               dmem_wdata;
  logic [31:0]               dmem_rdata;
  logic                      dmem_resp;

  logic                      cdb_valid;
  logic [PHYS_WIDTH-1:0]     cdb_pd;
  logic [ROB_ADDR_WIDTH-1:0] cdb_rob_idx;
  logic [31:0]               cdb_data;
  logic                      store_done;
  logic [ROB_ADDR_WIDTH-1:0] store_rob_idx;

  // master: queue + memory + ROB side; slave: the memory unit
  modport master (
    output br_flush, req_valid, req_store, req_funct3, req_rs1_data, req_rs2_data,
           req_imm, req_pd, req_rob_idx, dmem_rdata, dmem_resp,
    input  stall_mem, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
           cdb_valid, cdb_pd, cdb_rob_idx, cdb_data, store_done, store_rob_idx
  );

  modport slave (
    input  br_flush, req_valid, req_store, req_funct3, req_rs1_data, req_rs2_data,
           req_imm, req_pd, req_rob_idx, dmem_rdata, dmem_resp,
    output stall_mem, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
           cdb_valid, cdb_pd, cdb_rob_idx, cdb_data, store_done, store_rob_idx
  );
endinterface

// File: rtl/dmem_align.sv
// Byte-lane logic: request masks, store lane placement, load extract and extend.
module dmem_align
  import rv32i_types::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  ea_lo_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  mask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);
  logic [31:0] shifted;

  always_comb begin
    mask_o  = '0;
    wdata_o = '0;
    shifted = rdata_i >> {ea_lo_i, 3'b000};
    ldata_o = shifted;
    if (is_store_i) begin
      case (funct3_i)
        store_f3_sb: begin
          mask_o  = 4'b0001 << ea_lo_i;
          wdata_o = {24'b0, rs2_i[7:0]} << {ea_lo_i, 3'b000};
        end
        store_f3_sh: begin
          mask_o  = 4'b0011 << {ea_lo_i[1], 1'b0};
          wdata_o = {16'b0, rs2_i[15:0]} << {ea_lo_i[1], 4'b0000};
        end
        store_f3_sw: begin
          mask_o  = 4'b1111;
          wdata_o = rs2_i;
        end
        default: ;
      endcase
    end else begin
      case (funct3_i)
        load_f3_lb: begin
          mask_o  = 4'b0001 << ea_lo_i;
          ldata_o = {{24{shifted[7]}}, shifted[7:0]};
        end
        load_f3_lbu: begin
          mask_o  = 4'b0001 << ea_lo_i;
          ldata_o = {24'b0, shifted[7:0]};
        end
        load_f3_lh: begin
          mask_o  = 4'b0011 << {ea_lo_i[1], 1'b0};
          ldata_o = {{16{shifted[15]}}, shifted[15:0]};
        end
        load_f3_lhu: begin
          mask_o  = 4'b0011 << {ea_lo_i[1], 1'b0};
          ldata_o = {16'b0, shifted[15:0]};
        end
        load_f3_lw: begin
          mask_o  = 4'b1111;
          ldata_o = rdata_i;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/dmem_unit.sv
// Memory functional unit: one load/store in flight, dmem handshake, CDB/ROB reporting.
module dmem_unit
  import rv32i_types::*;
#(
  parameter int PHYS_WIDTH     = 6,
  parameter int ROB_ADDR_WIDTH = 5
) (
  input logic        clk,
  input logic        rst,
  dmem_unit_if.slave bus
);
  dmem_state_t               state_q;
  logic                      store_q;
  logic [2:0]                funct3_q;
  logic [1:0]                ea_lo_q;
  logic [PHYS_WIDTH-1:0]     pd_q;
  logic [ROB_ADDR_WIDTH-1:0] rob_q;
  logic [31:0]               addr_q, wdata_q;
  logic [3:0]                rmask_q, wmask_q;
  logic                      cdb_valid_q, store_done_q;
  logic [PHYS_WIDTH-1:0]     cdb_pd_q;
  logic [ROB_ADDR_WIDTH-1:0] cdb_rob_q, store_rob_q;
  logic [31:0]               cdb_data_q;

  logic        idle;
  logic [31:0] ea_d;
  logic        sel_store;
  logic [2:0]  sel_f3;
  logic [1:0]  sel_ea;
  logic [3:0]  mask_d;
  logic [31:0] wdata_d, ldata_d;

  assign idle = (state_q == DMEM_IDLE);
  assign ea_d = bus.req_rs1_data + bus.req_imm;

  // One aligner serves both ends: the incoming packet while idle, the held one otherwise
  assign sel_store = idle ? bus.req_store  : store_q;
  assign sel_f3    = idle ? bus.req_funct3 : funct3_q;
  assign sel_ea    = idle ? ea_d[1:0]      : ea_lo_q;

  dmem_align u_align (
    .is_store_i (sel_store),
    .funct3_i   (sel_f3),
    .ea_lo_i    (sel_ea),
    .rs2_i      (bus.req_rs2_data),
    .rdata_i    (bus.dmem_rdata),
    .mask_o     (mask_d),
    .wdata_o    (wdata_d),
    .ldata_o    (ldata_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= DMEM_IDLE;
      store_q      <= 1'b0;
      funct3_q     <= '0;
      ea_lo_q      <= '0;
      pd_q         <= '0;
      rob_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rmask_q      <= '0;
      wmask_q      <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_pd_q     <= '0;
      cdb_rob_q    <= '0;
      cdb_data_q   <= '0;
      store_done_q <= 1'b0;
      store_rob_q  <= '0;
    end else begin
      cdb_valid_q  <= 1'b0;
      store_done_q <= 1'b0;
      case (state_q)
        DMEM_IDLE: begin
          if (bus.req_valid && !bus.br_flush) begin
            store_q  <= bus.req_store;
            funct3_q <= bus.req_funct3;
            ea_lo_q  <= ea_d[1:0];
            pd_q     <= bus.req_pd;
            rob_q    <= bus.req_rob_idx;
            addr_q   <= {ea_d[31:2], 2'b00};
            rmask_q  <= bus.req_store ? 4'b0000 : mask_d;
            wmask_q  <= bus.req_store ? mask_d : 4'b0000;
            wdata_q  <= wdata_d;
            state_q  <= DMEM_REQ;
          end
        end
        DMEM_REQ: begin
          rmask_q <= '0;
          wmask_q <= '0;
          state_q <= (bus.br_flush && !store_q) ? DMEM_DRAIN : DMEM_WAIT;
        end
        DMEM_WAIT: begin
          if (bus.dmem_resp) begin
            state_q <= DMEM_IDLE;
            if (store_q) begin
              store_done_q <= 1'b1;
              store_rob_q  <= rob_q;
            end else if (!bus.br_flush) begin
              cdb_valid_q <= 1'b1;
              cdb_pd_q    <= pd_q;
              cdb_rob_q   <= rob_q;
              cdb_data_q  <= (pd_q == '0) ? 32'd0 : ldata_d;
            end
          end else if (bus.br_flush && !store_q) begin
            state_q <= DMEM_DRAIN;
          end
        end
        DMEM_DRAIN: begin
          // the squashed load's response is absorbed here and dropped
          if (bus.dmem_resp) state_q <= DMEM_IDLE;
        end
        default: state_q <= DMEM_IDLE;
      endcase
    end
  end

  assign bus.stall_mem     = !idle;
  assign bus.dmem_addr     = addr_q;
  assign bus.dmem_rmask    = rmask_q;
  assign bus.dmem_wmask    = wmask_q;
  assign bus.dmem_wdata    = wdata_q;
  assign bus.cdb_valid     = cdb_valid_q;
  assign bus.cdb_pd        = cdb_pd_q;
  assign bus.cdb_rob_idx   = cdb_rob_q;
  assign bus.cdb_data      = cdb_data_q;
  assign bus.store_done    = store_done_q;
  assign bus.store_rob_idx = store_rob_q;
endmodule

// File: tb/tb_dmem_unit.sv
// Scoreboard bench for dmem_unit: driver pushes expected writebacks, negedge monitor pops them.
module tb_dmem_unit;
  import rv32i_types::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_unit_if #(.PHYS_WIDTH(6), .ROB_ADDR_WIDTH(5)) dif ();

  dmem_unit #(.PHYS_WIDTH(6), .ROB_ADDR_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  typedef struct {
    logic        st;
    logic [4:0]  rob;
    logic [5:0]  pd;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;
  int   opn   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dif.cdb_valid || dif.store_done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out", {30'b0, dif.cdb_valid, dif.store_done}, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("out_kind", {30'b0, dif.cdb_valid, dif.store_done}, mon_e.st ? 32'd1 : 32'd2);
        if (mon_e.st) begin
          chk("store_rob", dif.store_rob_idx, mon_e.rob);
        end else begin
          chk("cdb_pd", dif.cdb_pd, mon_e.pd);
          chk("cdb_rob", dif.cdb_rob_idx, mon_e.rob);
          chk("cdb_data", dif.cdb_data, mon_e.data);
        end
      end
    end
  end

  // d: cycles from request to response (>=1); fl: cycle (1=REQ) carrying br_flush, 0=none
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] rs1,
                       input logic [31:0] imm, input logic [31:0] rs2, input logic [5:0] pd,
                       input logic [4:0] rob, input logic [31:0] rdata, input int d,
                       input int fl, input bit keep, input logic [31:0] e_addr,
                       input logic [3:0] e_mask, input logic [31:0] e_wdata,
                       input logic [31:0] e_data);
    int   wt;
    int   stall_n;
    exp_t e;
    opn++;
    wt = 0;
    while (dif.stall_mem && wt < 50) begin
      @(negedge clk);
      wt++;
    end
    if (wt >= 50) chk($sformatf("op%0d_idle_timeout", opn), 32'd1, 32'd0);
    dif.req_valid    = 1'b1;
    dif.req_store    = st;
    dif.req_funct3   = f3;
    dif.req_rs1_data = rs1;
    dif.req_imm      = imm;
    dif.req_rs2_data = rs2;
    dif.req_pd       = pd;
    dif.req_rob_idx  = rob;
    if (st || fl == 0 || fl > d + 1) begin
      e.st = st; e.rob = rob; e.pd = pd; e.data = e_data;
      sbq.push_back(e);
    end
    @(negedge clk);
    if (!keep) dif.req_valid = 1'b0;
    stall_n = 0;
    for (int k = 1; k <= d + 1; k++) begin
      dif.br_flush   = (k == fl);
      dif.dmem_resp  = (k == d + 1);
      dif.dmem_rdata = (k == d + 1) ? rdata : $urandom;
      if (k == 1) begin
        chk($sformatf("op%0d_stall_req", opn), dif.stall_mem, 32'd1);
        chk($sformatf("op%0d_addr", opn), dif.dmem_addr, e_addr);
        chk($sformatf("op%0d_rmask", opn), dif.dmem_rmask, st ? 4'b0000 : e_mask);
        chk($sformatf("op%0d_wmask", opn), dif.dmem_wmask, st ? e_mask : 4'b0000);
        chk($sformatf("op%0d_wdata", opn), dif.dmem_wdata, e_wdata);
      end
      if (k == 2)
        chk($sformatf("op%0d_mask_clr", opn), {dif.dmem_rmask, dif.dmem_wmask}, 32'd0);
      stall_n += int'(dif.stall_mem);
      @(negedge clk);
    end
    dif.br_flush  = 1'b0;
    dif.dmem_resp = 1'b0;
    chk($sformatf("op%0d_stall_low", opn), dif.stall_mem, 32'd0);
    chk($sformatf("op%0d_stall_cycles", opn), stall_n, d + 1);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_stall"}, dif.stall_mem, 32'd0);
    chk({pfx, "_addr"}, dif.dmem_addr, 32'd0);
    chk({pfx, "_masks"}, {dif.dmem_rmask, dif.dmem_wmask}, 32'd0);
    chk({pfx, "_wdata"}, dif.dmem_wdata, 32'd0);
    chk({pfx, "_cdb_valid"}, dif.cdb_valid, 32'd0);
    chk({pfx, "_cdb_pd"}, dif.cdb_pd, 32'd0);
    chk({pfx, "_cdb_rob"}, dif.cdb_rob_idx, 32'd0);
    chk({pfx, "_cdb_data"}, dif.cdb_data, 32'd0);
    chk({pfx, "_store_done"}, dif.store_done, 32'd0);
    chk({pfx, "_store_rob"}, dif.store_rob_idx, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    dif.br_flush = 0; dif.req_valid = 0; dif.req_store = 0; dif.req_funct3 = 0;
    dif.req_rs1_data = 0; dif.req_rs2_data = 0; dif.req_imm = 0; dif.req_pd = 0;
    dif.req_rob_idx = 0; dif.dmem_rdata = 0; dif.dmem_resp = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // st f3 rs1 imm rs2 pd rob rdata d fl keep | addr mask wdata data
    do_op(0, load_f3_lw,  32'h1000, 32'd4, 32'h0, 6'd5, 5'd1, 32'hDEADBEEF, 1, 0, 0,
          32'h1004, 4'b1111, 32'h0, 32'hDEADBEEF);
    do_op(0, load_f3_lb,  32'h1000, 32'd3, 32'h0, 6'd6, 5'd2, 32'h80123456, 2, 0, 0,
          32'h1000, 4'b1000, 32'h0, 32'hFFFFFF80);
    do_op(0, load_f3_lbu, 32'h1000, 32'd3, 32'h0, 6'd7, 5'd3, 32'h80123456, 1, 0, 0,
          32'h1000, 4'b1000, 32'h0, 32'h00000080);
    do_op(1, store_f3_sh, 32'h2000, 32'd2, 32'h1234ABCD, 6'd0, 5'd4, 32'h0, 1, 0, 0,
          32'h2000, 4'b1100, 32'hABCD0000, 32'h0);
    do_op(0, load_f3_lh,  32'h3006, 32'hFFFFFFFC, 32'h0, 6'd8, 5'd5, 32'h80011234, 1, 0, 0,
          32'h3000, 4'b1100, 32'h0, 32'hFFFF8001);
    do_op(0, load_f3_lhu, 32'h3000, 32'd0, 32'h0, 6'd9, 5'd6, 32'h0000F00F, 3, 0, 0,
          32'h3000, 4'b0011, 32'h0, 32'h0000F00F);
    do_op(1, store_f3_sb, 32'h4000, 32'd1, 32'h123456AA, 6'd0, 5'd7, 32'h0, 1, 0, 0,
          32'h4000, 4'b0010, 32'h0000AA00, 32'h0);
    do_op(1, store_f3_sw, 32'h4000, 32'd4, 32'hCAFEF00D, 6'd0, 5'd8, 32'h0, 2, 0, 0,
          32'h4004, 4'b1111, 32'hCAFEF00D, 32'h0);
    // writes to x0 still pulse the CDB but carry zero data
    do_op(0, load_f3_lw,  32'h5000, 32'd0, 32'h0, 6'd0, 5'd9, 32'h11223344, 1, 0, 0,
          32'h5000, 4'b1111, 32'h0, 32'h0);
    // address wraps past 2^32
    do_op(0, load_f3_lb,  32'hFFFFFFFE, 32'd3, 32'h0, 6'd10, 5'd10, 32'h00007F00, 1, 0, 0,
          32'h0, 4'b0010, 32'h0, 32'h0000007F);

    // flushed load in WAIT, response 3 cycles later, then an immediate accept
    do_op(0, load_f3_lw,  32'h6000, 32'd8, 32'h0, 6'd11, 5'd11, 32'hBADBAD00, 4, 2, 0,
          32'h6008, 4'b1111, 32'h0, 32'h0);
    do_op(0, load_f3_lbu, 32'h6000, 32'd2, 32'h0, 6'd12, 5'd12, 32'h00A50000, 1, 0, 0,
          32'h6000, 4'b0100, 32'h0, 32'h000000A5);
    // flushed load in REQ
    do_op(0, load_f3_lh,  32'h6100, 32'd0, 32'h0, 6'd13, 5'd13, 32'h12345678, 2, 1, 0,
          32'h6100, 4'b0011, 32'h0, 32'h0);
    // flush coinciding with the load response
    do_op(0, load_f3_lw,  32'h6200, 32'd0, 32'h0, 6'd14, 5'd14, 32'h87654321, 2, 3, 0,
          32'h6200, 4'b1111, 32'h0, 32'h0);
    // stores survive flush in REQ and in WAIT
    do_op(1, store_f3_sw, 32'h7000, 32'd0, 32'h55AA55AA, 6'd0, 5'd15, 32'h0, 2, 1, 0,
          32'h7000, 4'b1111, 32'h55AA55AA, 32'h0);
    do_op(1, store_f3_sb, 32'h7000, 32'd3, 32'h000000C3, 6'd0, 5'd16, 32'h0, 3, 2, 0,
          32'h7000, 4'b1000, 32'hC3000000, 32'h0);

    // back-to-back with req_valid held high throughout
    do_op(0, load_f3_lw,  32'h8000, 32'd0, 32'h0, 6'd17, 5'd17, 32'h01020304, 1, 0, 1,
          32'h8000, 4'b1111, 32'h0, 32'h01020304);
    do_op(1, store_f3_sh, 32'h8000, 32'd0, 32'h0000BEEF, 6'd0, 5'd18, 32'h0, 1, 0, 1,
          32'h8000, 4'b0011, 32'h0000BEEF, 32'h0);
    do_op(0, load_f3_lbu, 32'h8000, 32'd1, 32'h0, 6'd19, 5'd19, 32'h0000FE00, 1, 0, 0,
          32'h8000, 4'b0010, 32'h0, 32'h000000FE);

    // reset while a load waits in WAIT
    dif.req_valid = 1'b1; dif.req_store = 1'b0; dif.req_funct3 = load_f3_lw;
    dif.req_rs1_data = 32'h9000; dif.req_imm = 32'd0; dif.req_pd = 6'd20; dif.req_rob_idx = 5'd20;
    @(negedge clk);
    dif.req_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_stall", dif.stall_mem, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst_mid");
    rst = 1'b0;
    @(negedge clk);

    do_op(0, load_f3_lw,  32'hA000, 32'd0, 32'h0, 6'd21, 5'd21, 32'h0BADF00D, 1, 0, 0,
          32'hA000, 4'b1111, 32'h0, 32'h0BADF00D);
    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
